multicycle_sequencer: RTL and testbench

- Multicycle control FSM for the 16-bit simplified MIPS datapath: register file (4 x 16-bit, write on negedge), 16-bit ripple ALU, instruction memory.
- Sequences each instruction through fetch, decode, execute and writeback.
- Handshakes with a variable-latency instruction memory.
- Drives PC/IR load enables and all datapath controls; detects halt (16'hFFFF), illegal opcodes and fetch timeouts.

---
 rtl/seq_pkg.sv | 34 +++
 rtl/seq_decode.sv | 46 ++++
 rtl/multicycle_sequencer.sv | 172 +++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the multicycle sequencer: FSM states,
// opcodes, ALU control encodings and the decoder output bundle.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_PAUSE  = 3'd6
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_NOR  = 4'h4;
  localparam logic [3:0] OP_NAND = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  // {ainvert, binvert, op[1:0]}
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NAND = 4'b1101;

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode decoder: legality, halt detection and datapath
// controls used by the sequencer during EXEC and WB.
module seq_decode
  import seq_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       legal,
  output logic       is_halt,
  output logic       reg_dst,
  output logic       alu_src,
  output logic [3:0] alu_control
);

  always_comb begin
    legal       = 1'b1;
    is_halt     = 1'b0;
    reg_dst     = 1'b1;
    alu_src     = 1'b0;
    alu_control = ALU_ADD;
    case (opcode)
      OP_ADD:  alu_control = ALU_ADD;
      OP_SUB:  alu_control = ALU_SUB;
      OP_AND:  alu_control = ALU_AND;
      OP_OR:   alu_control = ALU_OR;
      OP_NOR:  alu_control = ALU_NOR;
      OP_NAND: alu_control = ALU_NAND;
      OP_SLT:  alu_control = ALU_SLT;
      OP_ADDI: begin
        reg_dst     = 1'b0;
        alu_src     = 1'b1;
        alu_control = ALU_ADD;
      end
      OP_HALT: begin
        legal   = 1'b0;
        is_halt = 1'b1;
        reg_dst = 1'b0;
      end
      default: begin
        legal       = 1'b0;
        reg_dst     = 1'b0;
        alu_control = ALU_AND;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM for the 16-bit MIPS datapath (fetch/decode/exec/wb).
// Optional single-step mode with a PAUSE state: define SEQ_SINGLE_STEP_EN.
//
// state  | meaning
// IDLE   | waiting for run
// FETCH  | imem_req high, waiting for imem_ack (bounded by FETCH_TIMEOUT)
// DECODE | classify IR opcode: halt, illegal NOP, or legal ALU op
// EXEC   | ALU controls driven, settle cycle
// WB     | register write and PC increment, retire count
// HALT   | terminal until reset
// PAUSE  | single-step only: wait for step between instructions
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int FETCH_TIMEOUT = 15,
  parameter int TO_W          = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             imem_ack,
  input  logic [15:0]      instr,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic             imem_req,
  output logic             ir_load,
  output logic             pc_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             alu_src,
  output logic [3:0]       alu_control,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic             fetch_err,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TIMEOUT - 1);

`ifdef SEQ_SINGLE_STEP_EN
  localparam state_t ST_AFTER_INSTR = ST_PAUSE;
`else
  localparam state_t ST_AFTER_INSTR = ST_FETCH;
`endif

  state_t           state_q, state_d;
  logic [15:0]      ir_q, ir_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             fetch_err_q, fetch_err_d;

  logic       dec_legal, dec_is_halt, dec_reg_dst, dec_alu_src;
  logic [3:0] dec_alu;

  // Operand fields of IR are consumed by the datapath's own copy of IR.
  logic unused_ir_fields;
  assign unused_ir_fields = ^ir_q[11:0];

  seq_decode u_decode (
    .opcode      (ir_q[15:12]),
    .legal       (dec_legal),
    .is_halt     (dec_is_halt),
    .reg_dst     (dec_reg_dst),
    .alu_src     (dec_alu_src),
    .alu_control (dec_alu)
  );

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    to_d        = to_q;
    cnt_d       = cnt_q;
    illegal_d   = illegal_q;
    fetch_err_d = fetch_err_q;
    imem_req    = 1'b0;
    ir_load     = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    alu_src     = 1'b0;
    alu_control = 4'b0000;
    busy        = 1'b0;
    halted      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        // ack wins even on the final allowed cycle
        if (imem_ack) begin
          ir_load = 1'b1;
          ir_d    = instr;
          to_d    = '0;
          state_d = ST_DECODE;
        end else if (to_q == TO_LAST) begin
          fetch_err_d = 1'b1;
          to_d        = '0;
          state_d     = ST_HALT;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      ST_DECODE: begin
        busy = 1'b1;
        if (dec_is_halt) begin
          state_d = ST_HALT;
        end else if (!dec_legal) begin
          illegal_d = 1'b1;
          pc_write  = 1'b1;
          state_d   = ST_AFTER_INSTR;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        busy        = 1'b1;
        reg_dst     = dec_reg_dst;
        alu_src     = dec_alu_src;
        alu_control = dec_alu;
        state_d     = ST_WB;
      end
      ST_WB: begin
        busy        = 1'b1;
        reg_dst     = dec_reg_dst;
        alu_src     = dec_alu_src;
        alu_control = dec_alu;
        reg_write   = 1'b1;
        pc_write    = 1'b1;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        state_d = ST_AFTER_INSTR;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
`ifdef SEQ_SINGLE_STEP_EN
      ST_PAUSE: begin
        if (step) state_d = ST_FETCH;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ir_q        <= '0;
      to_q        <= '0;
      cnt_q       <= '0;
      illegal_q   <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      to_q        <= to_d;
      cnt_q       <= cnt_d;
      illegal_q   <= illegal_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign illegal     = illegal_q;
  assign fetch_err   = fetch_err_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed, table-driven bench for multicycle_sequencer; adapts to the
// SEQ_SINGLE_STEP_EN build.
module tb_multicycle_sequencer;

  typedef struct packed {
    logic        imem_req;
    logic        ir_load;
    logic        pc_write;
    logic        reg_write;
    logic        reg_dst;
    logic        alu_src;
    logic [3:0]  alu;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic        fetch_err;
    logic [15:0] cnt;
  } outs_t;

  typedef struct {
    logic        run;
    logic        ack;
    logic        step;
    logic [15:0] instr;
    outs_t       exp;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset, run, imem_ack, step;
  logic [15:0] instr;
  logic        imem_req, ir_load, pc_write, reg_write, reg_dst, alu_src;
  logic [3:0]  alu_control;
  logic        busy, halted, illegal, fetch_err;
  logic [15:0] instr_count;

  always #5 clock = ~clock;

  multicycle_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .imem_ack    (imem_ack),
    .instr       (instr),
`ifdef SEQ_SINGLE_STEP_EN
    .step        (step),
`endif
    .imem_req    (imem_req),
    .ir_load     (ir_load),
    .pc_write    (pc_write),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .alu_src     (alu_src),
    .alu_control (alu_control),
    .busy        (busy),
    .halted      (halted),
    .illegal     (illegal),
    .fetch_err   (fetch_err),
    .instr_count (instr_count)
  );

`ifndef SEQ_SINGLE_STEP_EN
  logic unused_step;
  assign unused_step = step;
`endif

  outs_t act;
  assign act = {imem_req, ir_load, pc_write, reg_write, reg_dst, alu_src,
                alu_control, busy, halted, illegal, fetch_err, instr_count};

  int   total = 0;
  int   bad   = 0;
  vec_t prog[$];

  localparam logic [15:0] I_ADDI1 = 16'h710F;  // addi r1,15
  localparam logic [15:0] I_ADDI2 = 16'h7207;  // addi r2,7
  localparam logic [15:0] I_AND   = 16'h26C0;  // and r3,r1,r2
  localparam logic [15:0] I_ADD   = 16'h06C0;  // add r3,r1,r2
  localparam logic [15:0] I_SUB   = 16'h16C0;  // sub r3,r1,r2
  localparam logic [15:0] I_ILL   = 16'hA000;
  localparam logic [15:0] I_HALT  = 16'hFFFF;

  function automatic outs_t o(input logic rq, il, pw, rw, rd, as,
                              input logic [3:0] alu,
                              input logic bz, hl, ig, fe,
                              input logic [15:0] c);
    return {rq, il, pw, rw, rd, as, alu, bz, hl, ig, fe, c};
  endfunction

  task automatic check(input string name, input outs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // One cycle: drive just after the falling edge, outputs settle 1ns later.
  task automatic cyc(input logic r, input logic a, input logic [15:0] i, input logic s);
    @(negedge clock);
    run = r; imem_ack = a; instr = i; step = s;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; run = 1'b0; imem_ack = 1'b0; instr = '0; step = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  task automatic add(input logic r, a, input logic [15:0] i, input outs_t e, input logic s = 1'b0);
    vec_t v;
    v.run = r; v.ack = a; v.step = s; v.instr = i; v.exp = e;
    prog.push_back(v);
  endtask

  task automatic run_vecs(input string name);
    foreach (prog[k]) begin
      cyc(prog[k].run, prog[k].ack, prog[k].instr, prog[k].step);
      check($sformatf("%s[%0d]", name, k), prog[k].exp);
    end
    prog.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_req, n_ld, n_pw;
    int n;
    reset = 1'b1; run = 1'b0; imem_ack = 1'b0; instr = '0; step = 1'b0;
    do_reset();
    check("reset_outputs", '0);

`ifndef SEQ_SINGLE_STEP_EN
    // Zero-wait program: addi, addi, and, halt.
    add(1, 0, 16'h0,   o(0,0,0,0,0,0,4'b0000,0,0,0,0,0));
    add(0, 1, I_ADDI1, o(1,1,0,0,0,0,4'b0000,1,0,0,0,0));
    add(0, 0, 16'h0,   o(0,0,0,0,0,0,4'b0000,1,0,0,0,0));
    add(0, 0, 16'h0,   o(0,0,0,0,0,1,4'b0010,1,0,0,0,0));
    add(0, 0, 16'h0,   o(0,0,1,1,0,1,4'b0010,1,0,0,0,0));
    add(0, 1, I_ADDI2, o(1,1,0,0,0,0,4'b0000,1,0,0,0,1));
    add(0, 0, 16'h0,   o(0,0,0,0,0,0,4'b0000,1,0,0,0,1));
    add(0, 0, 16'h0,   o(0,0,0,0,0,1,4'b0010,1,0,0,0,1));
    add(0, 0, 16'h0,   o(0,0,1,1,0,1,4'b0010,1,0,0,0,1));
    add(0, 1, I_AND,   o(1,1,0,0,0,0,4'b0000,1,0,0,0,2));
    add(0, 0, 16'h0,   o(0,0,0,0,0,0,4'b0000,1,0,0,0,2));
    add(0, 0, 16'h0,   o(0,0,0,0,1,0,4'b0000,1,0,0,0,2));
    add(0, 0, 16'h0,   o(0,0,1,1,1,0,4'b0000,1,0,0,0,2));
    add(0, 1, I_HALT,  o(1,1,0,0,0,0,4'b0000,1,0,0,0,3));
    add(0, 0, 16'h0,   o(0,0,0,0,0,0,4'b0000,1,0,0,0,3));
    add(0, 0, 16'h0,   o(0,0,0,0,0,0,4'b0000,0,1,0,0,3));
    add(1, 1, I_ADD,   o(0,0,0,0,0,0,4'b0000,0,1,0,0,3));
    run_vecs("prog");

    // Illegal opcode then add then halt.
    do_reset();
    add(1, 0, 16'h0,   o(0,0,0,0,0,0,4'b0000,0,0,0,0,0));
    add(0, 1, I_ILL,   o(1,1,0,0,0,0,4'b0000,1,0,0,0,0));
    add(0, 0, 16'h0,   o(0,0,1,0,0,0,4'b0000,1,0,0,0,0));
    add(0, 1, I_ADD,   o(1,1,0,0,0,0,4'b0000,1,0,1,0,0));
    add(0, 0, 16'h0,   o(0,0,0,0,0,0,4'b0000,1,0,1,0,0));
    add(0, 0, 16'h0,   o(0,0,0,0,1,0,4'b0010,1,0,1,0,0));
    add(0, 0, 16'h0,   o(0,0,1,1,1,0,4'b0010,1,0,1,0,0));
    add(0, 1, I_HALT,  o(1,1,0,0,0,0,4'b0000,1,0,1,0,1));
    add(0, 0, 16'h0,   o(0,0,0,0,0,0,4'b0000,1,0,1,0,1));
    add(0, 0, 16'h0,   o(0,0,0,0,0,0,4'b0000,0,1,1,0,1));
    run_vecs("illegal");

    // First ack delayed by 3 cycles.
    do_reset();
    cyc(1, 0, 16'h0, 0);
    n_req = 0; n_ld = 0; n_pw = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(0, (k == 3), I_ADD, 0);
      n_req += int'(imem_req);
      n_ld  += int'(ir_load);
      n_pw  += int'(pc_write);
      if (k == 3) break;
    end
    check_val("delay_req_cycles", n_req, 4);
    check_val("delay_ir_load", n_ld, 1);
    cyc(0, 0, 16'h0, 0);
    n_pw += int'(pc_write);
    cyc(0, 0, 16'h0, 0);
    n_pw += int'(pc_write);
    check_val("delay_no_pc_write_before_wb", n_pw, 0);
    cyc(0, 0, 16'h0, 0);
    check("delay_wb", o(0,0,1,1,1,0,4'b0010,1,0,0,0,0));

    // Ack never arrives.
    do_reset();
    cyc(1, 0, 16'h0, 0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      cyc(0, 0, 16'h0, 0);
      if (!imem_req) break;
      n++;
    end
    check_val("timeout_fetch_cycles", n, 15);
    check("timeout_halt", o(0,0,0,0,0,0,4'b0000,0,1,0,1,0));

    // Ack on the 15th fetch cycle is still accepted.
    do_reset();
    cyc(1, 0, 16'h0, 0);
    for (int k = 1; k < 15; k++) cyc(0, 0, 16'h0, 0);
    check("late_ack_wait14", o(1,0,0,0,0,0,4'b0000,1,0,0,0,0));
    cyc(0, 1, I_ADD, 0);
    check("late_ack_load", o(1,1,0,0,0,0,4'b0000,1,0,0,0,0));
    cyc(0, 0, 16'h0, 0);
    check("late_ack_decode", o(0,0,0,0,0,0,4'b0000,1,0,0,0,0));

    // Reset during the second WB.
    do_reset();
    cyc(1, 0, 16'h0, 0);
    cyc(0, 1, I_ADD, 0);
    cyc(0, 0, 16'h0, 0);
    cyc(0, 0, 16'h0, 0);
    cyc(0, 0, 16'h0, 0);
    cyc(0, 1, I_ADD, 0);
    cyc(0, 0, 16'h0, 0);
    cyc(0, 0, 16'h0, 0);
    cyc(0, 0, 16'h0, 0);
    check("rst_wb_before", o(0,0,1,1,1,0,4'b0010,1,0,0,0,1));
    reset = 1'b1;
    cyc(0, 0, 16'h0, 0);
    check("rst_wb_after", '0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 16'h0, 0);
      check($sformatf("rst_idle_hold[%0d]", k), '0);
    end
`else
    // Single-step: two subs, PAUSE between them.
    add(1, 0, 16'h0, o(0,0,0,0,0,0,4'b0000,0,0,0,0,0));
    add(0, 1, I_SUB, o(1,1,0,0,0,0,4'b0000,1,0,0,0,0));
    add(0, 0, 16'h0, o(0,0,0,0,0,0,4'b0000,1,0,0,0,0));
    add(0, 0, 16'h0, o(0,0,0,0,1,0,4'b0110,1,0,0,0,0));
    add(0, 0, 16'h0, o(0,0,1,1,1,0,4'b0110,1,0,0,0,0));
    add(0, 0, 16'h0, o(0,0,0,0,0,0,4'b0000,0,0,0,0,1));
    add(1, 1, I_SUB, o(0,0,0,0,0,0,4'b0000,0,0,0,0,1));
    add(0, 0, 16'h0, o(0,0,0,0,0,0,4'b0000,0,0,0,0,1), 1'b1);
    add(0, 1, I_SUB, o(1,1,0,0,0,0,4'b0000,1,0,0,0,1));
    add(0, 0, 16'h0, o(0,0,0,0,0,0,4'b0000,1,0,0,0,1));
    add(0, 0, 16'h0, o(0,0,0,0,1,0,4'b0110,1,0,0,0,1));
    add(0, 0, 16'h0, o(0,0,1,1,1,0,4'b0110,1,0,0,0,1));
    add(0, 0, 16'h0, o(0,0,0,0,0,0,4'b0000,0,0,0,0,2));
    run_vecs("step");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
